// File: rtl/mac_sat_sequencer.sv
// mac_sat_sequencer: sequential FIR multiply-accumulate with saturation.
// One sample enters the delay line per transaction. MAC then runs for TAPS
// cycles on a single shared multiplier, SAT clips the result to N bits, and
// OUT holds it until the consumer accepts it.
// Optional feature: define MAC_SAT_ROUND_EN to round half up before the
// saturation check. Without it, the low F bits are truncated.
module mac_sat_sequencer #(
  parameter int N    = 25,
  parameter int F    = 14,
  parameter int TAPS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [N-1:0]             coef_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_data,
  output logic                     sat_flag,
  output logic [7:0]               sat_cnt,
  output logic                     busy
);

  localparam int AW   = $clog2(TAPS);
  localparam int ACCW = 2 * N + AW;
  localparam int HW   = ACCW - F;

  typedef enum logic [1:0] {IDLE, MAC, SAT, OUT} state_t;

  state_t                state_q, state_d;
  logic [N-1:0]          x_q [TAPS];
  logic [N-1:0]          x_d [TAPS];
  logic [N-1:0]          c_q [TAPS];
  logic [N-1:0]          c_d [TAPS];
  logic [AW-1:0]         k_q, k_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [N-1:0]          out_data_q, out_data_d;
  logic                  sat_flag_q, sat_flag_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            sat_cnt_q, sat_cnt_d;

  logic signed [2*N-1:0] mul_a, mul_b, prod;
  logic [HW-1:0]         acc_hi;
  logic                  fits;

  // Next-state, datapath and saturation logic for all registers.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    sat_flag_d  = sat_flag_q;
    out_valid_d = out_valid_q;
    sat_cnt_d   = sat_cnt_q;

    mul_a = {{N{x_q[k_q][N-1]}}, x_q[k_q]};
    mul_b = {{N{c_q[k_q][N-1]}}, c_q[k_q]};
    prod  = mul_a * mul_b;

    // Adding 2^(F-1) and then dropping F bits equals adding bit F-1 to the
    // kept upper bits, so only the upper slice of the accumulator is formed.
`ifdef MAC_SAT_ROUND_EN
    acc_hi = acc_q[ACCW-1:F] + {{(HW-1){1'b0}}, acc_q[F-1]};
`else
    acc_hi = acc_q[ACCW-1:F];
`endif
    fits = (acc_hi[HW-1:N-1] == '0) || (acc_hi[HW-1:N-1] == '1);

    case (state_q)
      IDLE: begin
        if (coef_we) c_d[coef_addr] = coef_data;
        if (in_valid) begin
          x_d[0] = in_data;
          for (int unsigned i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{AW{prod[2*N-1]}}, prod};
        k_d   = k_q + 1'b1;
        if (k_q == AW'(TAPS - 1)) state_d = SAT;
      end
      SAT: begin
        if (fits) begin
          out_data_d = acc_hi[N-1:0];
          sat_flag_d = 1'b0;
        end else begin
          out_data_d = acc_hi[HW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
          sat_flag_d = 1'b1;
          if (sat_cnt_q != 8'hFF) sat_cnt_d = sat_cnt_q + 8'd1;
        end
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous clear of every stored value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      sat_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      c_q         <= c_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      sat_flag_q  <= sat_flag_d;
      out_valid_q <= out_valid_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_flag_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_mac_sat_sequencer.sv
// Self-checking bench for mac_sat_sequencer. The reference model is a dot
// product over integer arrays followed by an arithmetic shift and clamp.
module tb_mac_sat_sequencer;

  localparam int N    = 25;
  localparam int F    = 14;
  localparam int TAPS = 8;
  localparam int AW   = $clog2(TAPS);

  logic          clk = 1'b0;
  logic          reset;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [N-1:0]  coef_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          sat_flag;
  logic [7:0]    sat_cnt;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state.
  longint x_m [TAPS];
  longint c_m [TAPS];
  int     sat_m;

  mac_sat_sequencer #(.N(N), .F(F), .TAPS(TAPS)) dut (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_flag(sat_flag), .sat_cnt(sat_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic longint sx(input logic [N-1:0] v);
    return v[N-1] ? longint'(v) - (longint'(1) << N) : longint'(v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      x_m[i] = 0;
      c_m[i] = 0;
    end
    sat_m = 0;
  endfunction

  // Expected result for the current model delay line and coefficients.
  function automatic void model_eval(output logic [N-1:0] d, output logic f);
    longint acc = 0;
    longint q;
    longint qmax = (longint'(1) << (N - 1)) - 1;
    longint qmin = -(longint'(1) << (N - 1));
    for (int i = 0; i < TAPS; i++) acc += x_m[i] * c_m[i];
`ifdef MAC_SAT_ROUND_EN
    acc += longint'(1) << (F - 1);
`endif
    q = acc >>> F;
    if (q > qmax) begin
      d = 25'h0FFFFFF; f = 1'b1;
    end else if (q < qmin) begin
      d = 25'h1000000; f = 1'b1;
    end else begin
      d = q[N-1:0]; f = 1'b0;
    end
    if (f && sat_m < 255) sat_m++;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_coef(input int a, input logic [N-1:0] v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = AW'(a); coef_data = v;
    @(negedge clk);
    coef_we = 1'b0;
    c_m[a] = sx(v);
  endtask

  // Offers one sample (optionally with a coefficient write in the same
  // cycle) and waits for the result; edges counts clocks after acceptance.
  task automatic send_sample(input logic [N-1:0] x, input bit we, input int a,
                             input logic [N-1:0] cd, output logic [N-1:0] d,
                             output logic f, output int edges);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; in_data = x;
    coef_we = we; coef_addr = AW'(a); coef_data = cd;
    @(posedge clk);
    #1;
    in_valid = 1'b0; coef_we = 1'b0;
    if (we) c_m[a] = sx(cd);
    for (int i = TAPS - 1; i > 0; i--) x_m[i] = x_m[i-1];
    x_m[0] = sx(x);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
    d = out_data;
    f = sat_flag;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, busy, out_valid, sat_flag} !== 4'b1000 || out_data !== '0 || sat_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b busy=%b valid=%b flag=%b data=%h cnt=%0d, want 1 0 0 0 0 0",
               in_ready, busy, out_valid, sat_flag, out_data, sat_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_unity();
    logic [N-1:0] d; logic f; int e;
    do_reset();
    write_coef(0, 25'h0004000);
    send_sample(25'h0008000, 1'b0, 0, '0, d, f, e);
    n_checks++;
    if (d !== 25'h0008000 || f !== 1'b0) begin
      n_fail++;
      $display("FAIL unity_gain: got %h flag %b, want 0008000 flag 0", d, f);
    end
    n_checks++;
    if (e !== TAPS + 1) begin
      n_fail++;
      $display("FAIL latency: got %0d edges after accept, want %0d", e, TAPS + 1);
    end
  endtask

  task automatic test_saturate();
    logic [N-1:0] d, ed; logic f, ef; int e;
    do_reset();
    write_coef(0, 25'h0400000);
    send_sample(25'h0400000, 1'b0, 0, '0, d, f, e);
    model_eval(ed, ef);
    n_checks++;
    if (d !== 25'h0FFFFFF || f !== 1'b1 || sat_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL sat_positive: got %h flag %b cnt %0d, want 0FFFFFF 1 1", d, f, sat_cnt);
    end
    send_sample(25'h1C00000, 1'b0, 0, '0, d, f, e);
    model_eval(ed, ef);
    n_checks++;
    if (d !== 25'h1000000 || f !== 1'b1 || sat_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL sat_negative: got %h flag %b cnt %0d, want 1000000 1 2", d, f, sat_cnt);
    end
  endtask

  task automatic test_round();
    logic [N-1:0] d, want; logic f; int e;
`ifdef MAC_SAT_ROUND_EN
    want = 25'h0000001;
`else
    want = 25'h0000000;
`endif
    do_reset();
    write_coef(0, 25'h0002000);
    send_sample(25'h0000001, 1'b0, 0, '0, d, f, e);
    n_checks++;
    if (d !== want || f !== 1'b0) begin
      n_fail++;
      $display("FAIL rounding: got %h flag %b, want %h flag 0", d, f, want);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] d, held, ed; logic f, hf, ef; int e;
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, N'($urandom_range(1, 4000)));
    out_ready = 1'b0;
    send_sample(N'($urandom_range(1, 60000)), 1'b0, 0, '0, held, hf, e);
    model_eval(ed, ef);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      coef_we = 1'b1; coef_addr = '0; coef_data = ~N'(c_m[0]);
      in_valid = 1'b1; in_data = N'($urandom);
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held || sat_flag !== hf) begin
        n_fail++;
        $display("FAIL backpressure_hold: got valid=%b ready=%b data=%h flag=%b, want 1 0 %h %b",
                 out_valid, in_ready, out_data, sat_flag, held, hf);
      end
    end
    @(negedge clk);
    coef_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
    end
    send_sample(N'($urandom_range(1, 60000)), 1'b0, 0, '0, d, f, e);
    model_eval(ed, ef);
    n_checks++;
    if (d !== ed || f !== ef) begin
      n_fail++;
      $display("FAIL backpressure_after: got %h flag %b, want %h flag %b", d, f, ed, ef);
    end
  endtask

  task automatic test_reset_mid_mac();
    logic [N-1:0] d; logic f; int e; int seen = 0;
    do_reset();
    for (int i = 0; i < TAPS; i++) write_coef(i, N'($urandom_range(1, 4000)));
    @(negedge clk);
    in_valid = 1'b1; in_data = 25'h0012345;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, busy, out_valid, sat_flag} !== 4'b1000 || out_data !== '0 || sat_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mac: got ready=%b busy=%b valid=%b flag=%b data=%h cnt=%0d, want 1 0 0 0 0 0",
               in_ready, busy, out_valid, sat_flag, out_data, sat_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_valid: got %0d valid cycles after reset, want 0", seen);
    end
    send_sample(N'($urandom), 1'b0, 0, '0, d, f, e);
    n_checks++;
    if (d !== '0 || f !== 1'b0 || e >= 50) begin
      n_fail++;
      $display("FAIL zero_coefs: got %h flag %b edges %0d, want 0 flag 0", d, f, e);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] d, ed, x, cd; logic f, ef; int e; bit we; int a;
    do_reset();
    for (int i = 0; i < TAPS; i++)
      write_coef(i, N'(longint'($urandom_range(0, 131072)) - 65536));
    for (int n = 0; n < 24; n++) begin
      x  = N'(longint'($urandom_range(0, 2097152)) - 1048576);
      we = ($urandom_range(0, 2) == 0);
      a  = $urandom_range(0, TAPS - 1);
      cd = N'(longint'($urandom_range(0, 131072)) - 65536);
      send_sample(x, we, a, cd, d, f, e);
      model_eval(ed, ef);
      n_checks++;
      if (d !== ed || f !== ef || e >= 50 || sat_cnt !== 8'(sat_m)) begin
        n_fail++;
        $display("FAIL random_%0d: got %h flag %b cnt %0d edges %0d, want %h flag %b cnt %0d",
                 n, d, f, sat_cnt, e, ed, ef, sat_m);
      end
    end
  endtask

  task automatic test_sat_count();
    logic [N-1:0] d, ed; logic f, ef; int e;
    do_reset();
    write_coef(0, 25'h0400000);
    for (int n = 1; n <= 300; n++) begin
      send_sample(25'h0400000, 1'b0, 0, '0, d, f, e);
      model_eval(ed, ef);
      if (n == 254 || n == 255 || n == 256 || n == 300) begin
        n_checks++;
        if (sat_cnt !== 8'(sat_m) || f !== 1'b1) begin
          n_fail++;
          $display("FAIL sat_cnt_%0d: got %0d flag %b, want %0d flag 1", n, sat_cnt, f, sat_m);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_reset();
    test_reset();
    test_unity();
    test_saturate();
    test_round();
    test_backpressure();
    test_reset_mid_mac();
    test_random();
    test_sat_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
